reaction_timer: RTL and testbench
=================================

# reaction_timer

Measures driver reaction time for the starting-light game: counts milliseconds from lights-out to the driver's button press, flags jump starts and timeouts, and holds the best clean time. Sits beside the light-sequence FSM and random-delay block: the FSM's sequence-start and lights-out pulses drive it, and its millisecond result feeds the binary-to-BCD / seven-segment display path. Runs on the system clock with the shared 1 kHz tick as count enable.

## Interface
Parameters:
- MAX_MS, default 9999: timeout and saturation value in ms; must fit in 14 bits.
- SYNC_STAGES, default 2: flip-flop stages on the raw button input (≥2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  1 ms enable pulse, exactly one clk wide.
- arm  in  1  one-cycle pulse at start of a light sequence.
- lights_out  in  1  one-cycle pulse when all lights extinguish.
- press_n  in  1  raw push-button, active-low, asynchronous to clk.
- react_ms  out  14  latched result in ms.
- best_ms  out  14  best clean result since reset.
- valid  out  1  high while a result is held (DONE state).
- jump_start  out  1  result was a press before lights-out.
- timeout  out  1  no press within MAX_MS.
- busy  out  1  high in ARMED or TIMING.

## Operation
- press_n inverted, passed through SYNC_STAGES flops → press_s; press event = rising edge of press_s (press_s=1, previous=0). Held button gives one event only.
- States: IDLE, ARMED, TIMING, DONE. Reset → IDLE.
- IDLE: lights_out and press ignored. arm → ARMED.
- ARMED: clears valid/jump_start/timeout, count=0. Press event → DONE, jump_start=1, react_ms=0. lights_out (no press) → TIMING, count=0.
- TIMING: count increments by 1 on each tick. Press event → DONE, react_ms=count (value before this cycle's update, i.e. tick coincident with press is not counted). count reaches MAX_MS → DONE, timeout=1, react_ms=MAX_MS; count never exceeds MAX_MS.
- DONE: valid=1, outputs held until arm → ARMED. Press and lights_out ignored.
- best_ms updated on entry to DONE only for clean result (jump_start=0, timeout=0) with react_ms < best_ms.
- Priorities: arm beats everything in every state (including TIMING: restart, no result); in ARMED press event beats lights_out in the same cycle (jump start); in TIMING press event beats timeout in the same cycle.
- Counter width 14 bits, unsigned; no wrap possible because of MAX_MS saturation.

## Timing
- Reset values: react_ms=0, best_ms=MAX_MS, valid=0, jump_start=0, timeout=0, busy=0, state IDLE, sync flops 0 (released).
- rst asserted in any state, mid-count included: all of the above at next edge; best_ms lost.
- Press latency: press_n falling at cycle N → press event at cycle N+SYNC_STAGES (±1 for metastability), DONE/valid registered one cycle later.
- arm at cycle N → busy=1, valid=0 at N+1. lights_out at N → TIMING at N+1; a tick at cycle N is not counted, first counted tick is at N+1 or later.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Clean run: arm, lights_out, 237 ticks, then press → valid=1, react_ms=237, jump_start=0, timeout=0, best_ms=237.
- Jump start: arm, press before lights_out → valid=1, jump_start=1, react_ms=0, best_ms unchanged; later lights_out ignored.
- Timeout: arm, lights_out, no press for MAX_MS ticks → timeout=1, react_ms=9999; further ticks do not change it.
- Best tracking: clean runs of 300, 180, 250 ms (re-arm between) → best_ms 300, 180, 180; held button across re-arm gives no event until released and pressed again.
- Simultaneous events: press event and lights_out same cycle in ARMED → jump start; arm during TIMING at count 50 → ARMED, valid=0, no best update.
- Reset mid-TIMING at count 120 → all outputs reset values, best_ms=9999, state IDLE; lights_out afterward ignored.

Source files
------------

// File: rtl/reaction_timer.sv
// reaction_timer: measures ms from lights-out to button press, flags jump starts/timeouts, tracks best time
module reaction_timer #(
  parameter int MAX_MS      = 9999,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        arm,
  input  logic        lights_out,
  input  logic        press_n,
  output logic [13:0] react_ms,
  output logic [13:0] best_ms,
  output logic        valid,
  output logic        jump_start,
  output logic        timeout,
  output logic        busy
);
  localparam logic [13:0] MAX = 14'(MAX_MS);
  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  logic [13:0] count_q, count_d, react_q, react_d, best_q, best_d;
  logic jump_q, jump_d, tout_q, tout_d;
  logic press_s, press_ev;
  assign press_s  = sync_q[SYNC_STAGES-1];
  assign press_ev = press_s & ~prev_q;
  // button synchroniser plus edge history, so a held button yields a single event
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ~press_n};
      prev_q <= press_s;
    end
  end
  // state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      react_q <= '0;
      best_q  <= MAX;
      jump_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      react_q <= react_d;
      best_q  <= best_d;
      jump_q  <= jump_d;
      tout_q  <= tout_d;
    end
  end
  // next state: arm restarts from anywhere; press wins over lights_out and over timeout
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    react_d = react_q;
    best_d  = best_q;
    jump_d  = jump_q;
    tout_d  = tout_q;
    if (arm) begin
      state_d = ARMED;
      count_d = '0;
      jump_d  = 1'b0;
      tout_d  = 1'b0;
    end else begin
      case (state_q)
        ARMED:
          if (press_ev) begin
            state_d = DONE;
            jump_d  = 1'b1;
            react_d = '0;
          end else if (lights_out) begin
            state_d = TIMING;
            count_d = '0;
          end
        TIMING:
          if (press_ev) begin
            state_d = DONE;
            react_d = count_q;
            best_d  = count_q < best_q ? count_q : best_q;
          end else if (tick) begin
            count_d = count_q + 14'd1;
            if (count_d == MAX) begin
              state_d = DONE;
              tout_d  = 1'b1;
              react_d = MAX;
            end
          end
        default: ;
      endcase
    end
  end
  assign react_ms   = react_q;
  assign best_ms    = best_q;
  assign jump_start = jump_q;
  assign timeout    = tout_q;
  assign valid      = state_q == DONE;
  assign busy       = state_q == ARMED || state_q == TIMING;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed checks of reaction_timer against hand-computed results
module tb_reaction_timer;
  logic clk = 0, rst = 1, tick = 0, arm = 0, lights_out = 0, press_n = 1;
  logic [13:0] react_ms, best_ms;
  logic valid, jump_start, timeout, busy;
  int total = 0, bad = 0;
  reaction_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .arm(arm), .lights_out(lights_out), .press_n(press_n),
    .react_ms(react_ms), .best_ms(best_ms), .valid(valid), .jump_start(jump_start),
    .timeout(timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_arm();
    arm = 1; cyc(); arm = 0;
  endtask
  task automatic do_lo();
    lights_out = 1; cyc(); lights_out = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1; cyc(); tick = 0; cyc();
    end
  endtask
  task automatic press();
    press_n = 0; cyc(3);
  endtask
  task automatic release_btn();
    press_n = 1; cyc(3);
  endtask
  task automatic clean_run(input int ms, input int best, input string tag);
    do_arm(); do_lo(); ticks(ms); press();
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_react"}, react_ms, ms);
    chk({tag, "_best"}, best_ms, best);
    release_btn();
  endtask
  initial begin
    cyc(2); rst = 0;
    chk("rst_react", react_ms, 0);
    chk("rst_best", best_ms, 9999);
    chk("rst_flags", {valid, jump_start, timeout, busy}, 0);
    do_lo(); press();
    chk("idle_ignore", {valid, busy}, 0);
    release_btn();
    do_arm();
    chk("arm_busy", {busy, valid}, 2'b10);
    do_lo(); ticks(237);
    chk("timing_novalid", valid, 0);
    press();
    chk("clean_valid", valid, 1);
    chk("clean_react", react_ms, 237);
    chk("clean_flags", {jump_start, timeout, busy}, 0);
    chk("clean_best", best_ms, 237);
    release_btn();
    do_arm(); press();
    chk("jump_valid", valid, 1);
    chk("jump_flag", jump_start, 1);
    chk("jump_react", react_ms, 0);
    chk("jump_best", best_ms, 237);
    release_btn(); do_lo(); ticks(3);
    chk("jump_hold", {valid, jump_start, busy}, 3'b110);
    do_arm();
    chk("rearm_clear", {valid, jump_start, timeout, busy}, 4'b0001);
    do_lo(); ticks(9998);
    chk("to_pre", {valid, timeout}, 0);
    ticks(1);
    chk("to_flag", {valid, timeout, jump_start}, 3'b110);
    chk("to_react", react_ms, 9999);
    ticks(5);
    chk("to_hold", react_ms, 9999);
    chk("to_best", best_ms, 237);
    rst = 1; cyc(); rst = 0;
    chk("rst2_best", best_ms, 9999);
    clean_run(300, 300, "b300");
    clean_run(180, 180, "b180");
    do_arm(); do_lo(); ticks(250); press();
    chk("b250_react", react_ms, 250);
    chk("b250_best", best_ms, 180);
    do_arm(); do_lo(); ticks(10);
    chk("held_noevent", {busy, valid}, 2'b10);
    release_btn(); ticks(5); press();
    chk("held_react", react_ms, 15);
    chk("held_best", best_ms, 15);
    release_btn();
    do_arm();
    press_n = 0; cyc(2); lights_out = 1; cyc(); lights_out = 0;
    chk("sim_jump", {valid, jump_start}, 2'b11);
    chk("sim_react", react_ms, 0);
    release_btn();
    do_arm(); do_lo(); ticks(50); do_arm();
    chk("arm_timing", {busy, valid}, 2'b10);
    chk("arm_timing_best", best_ms, 15);
    do_lo(); ticks(7); press();
    chk("restart_react", react_ms, 7);
    chk("restart_best", best_ms, 7);
    release_btn();
    do_arm(); do_lo(); ticks(120);
    rst = 1; cyc(); rst = 0;
    chk("midrst_react", react_ms, 0);
    chk("midrst_best", best_ms, 9999);
    chk("midrst_flags", {valid, jump_start, timeout, busy}, 0);
    do_lo(); ticks(5);
    chk("midrst_lo_ignored", {busy, valid}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
